// File: rtl/crc_check_byteen.sv
// Receive-side CRC checker for byte-enabled flit streams.
// Folds data+CRC bytes and compares the final value with the polynomial residue.
module crc_check_byteen #(
    parameter int                   DWIDTH        = 512,
    parameter int                   CRC_WIDTH     = 32,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY      = 32'h04C11DB7,
    parameter logic [CRC_WIDTH-1:0] INIT          = 32'hFFFFFFFF,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT       = 32'hFFFFFFFF,
    parameter bit                   REFIN         = 1'b1,
    parameter bit                   REFOUT        = 1'b1,
    parameter logic [CRC_WIDTH-1:0] CHECK_RESIDUE = 32'h2144DF1C
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DWIDTH-1:0]      din,
    input  logic [DWIDTH/8-1:0]    byteEn,
    input  logic                   dlast,
    input  logic                   flitEn,
    output logic                   crc_vld,
    output logic                   crc_ok,
    output logic                   crc_err,
    output logic                   runt,
    output logic [CRC_WIDTH-1:0]   crc_residue,
    output logic [31:0]            frame_cnt,
    output logic [31:0]            err_cnt
);

    localparam int NB = DWIDTH / 8;
    localparam int CB = CRC_WIDTH / 8;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic logic [CRC_WIDTH-1:0] revw(input logic [CRC_WIDTH-1:0] v);
        logic [CRC_WIDTH-1:0] r;
        for (int i = 0; i < CRC_WIDTH; i++) r[i] = v[CRC_WIDTH-1-i];
        return r;
    endfunction

    // Normal-form MSB-first update; reflected input bytes are mirrored first.
    function automatic logic [CRC_WIDTH-1:0] fold_byte(
        input logic [CRC_WIDTH-1:0] c,
        input logic [7:0]           b
    );
        logic [CRC_WIDTH-1:0] r;
        logic [7:0]           bb;
        bb = REFIN ? rev8(b) : b;
        r  = c ^ (CRC_WIDTH'(bb) << (CRC_WIDTH - 8));
        for (int k = 0; k < 8; k++)
            r = r[CRC_WIDTH-1] ? ((r << 1) ^ CRC_POLY) : (r << 1);
        return r;
    endfunction

    // Stage 1 input registers
    logic                 s1_vld_q;
    logic                 s1_last_q;
    logic [DWIDTH-1:0]    s1_din_q;
    logic [NB-1:0]        s1_be_q;

    // Stage 2 running state and end-of-frame snapshot
    logic [CRC_WIDTH-1:0] crc_q, crc_d, fold_crc;
    logic [15:0]          cnt_q, cnt_d, cnt_sat;
    logic [16:0]          byte_sum;
    logic                 fin_vld_q;
    logic [CRC_WIDTH-1:0] fin_crc_q;
    logic [15:0]          fin_cnt_q;

    // Stage 3 result registers
    logic                 vld_q, ok_q, err_q, runt_q;
    logic [CRC_WIDTH-1:0] res_q;
    logic [31:0]          fcnt_q, ecnt_q;
    logic [CRC_WIDTH-1:0] final_d;
    logic                 runt_d, ok_d;

    // Capture the incoming flit unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_din_q  <= '0;
            s1_be_q   <= '0;
        end else begin
            s1_vld_q  <= flitEn;
            s1_last_q <= dlast;
            s1_din_q  <= din;
            s1_be_q   <= byteEn;
        end
    end

    // Fold enabled bytes in ascending lane order and count them
    always_comb begin
        fold_crc = crc_q;
        byte_sum = {1'b0, cnt_q};
        for (int i = 0; i < NB; i++) begin
            if (s1_be_q[i]) begin
                fold_crc = fold_byte(fold_crc, s1_din_q[8*i +: 8]);
                byte_sum = byte_sum + 17'd1;
            end
        end
        cnt_sat = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
    end

    // Running state advances on data flits and rearms on the last one
    always_comb begin
        crc_d = crc_q;
        cnt_d = cnt_q;
        if (s1_vld_q) begin
            if (s1_last_q) begin
                crc_d = INIT;
                cnt_d = '0;
            end else begin
                crc_d = fold_crc;
                cnt_d = cnt_sat;
            end
        end
    end

    // Running CRC/count plus the snapshot handed to the result stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q     <= INIT;
            cnt_q     <= '0;
            fin_vld_q <= 1'b0;
            fin_crc_q <= '0;
            fin_cnt_q <= '0;
        end else begin
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            fin_vld_q <= s1_vld_q & s1_last_q;
            if (s1_vld_q && s1_last_q) begin
                fin_crc_q <= fold_crc;
                fin_cnt_q <= cnt_sat;
            end
        end
    end

    // Final transform and verdict for the snapshot
    always_comb begin
        final_d = (REFOUT ? revw(fin_crc_q) : fin_crc_q) ^ XOR_OUT;
        runt_d  = fin_cnt_q < 16'(CB);
        ok_d    = !runt_d && (final_d == CHECK_RESIDUE);
    end

    // Registered verdict, held until the next frame, with saturating counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            ok_q   <= 1'b0;
            err_q  <= 1'b0;
            runt_q <= 1'b0;
            res_q  <= '0;
            fcnt_q <= '0;
            ecnt_q <= '0;
        end else begin
            vld_q <= fin_vld_q;
            if (fin_vld_q) begin
                ok_q   <= ok_d;
                err_q  <= !ok_d;
                runt_q <= runt_d;
                res_q  <= final_d;
                if (fcnt_q != 32'hFFFFFFFF) fcnt_q <= fcnt_q + 32'd1;
                if (!ok_d && ecnt_q != 32'hFFFFFFFF) ecnt_q <= ecnt_q + 32'd1;
            end
        end
    end

    assign crc_vld     = vld_q;
    assign crc_ok      = ok_q;
    assign crc_err     = err_q;
    assign runt        = runt_q;
    assign crc_residue = res_q;
    assign frame_cnt   = fcnt_q;
    assign err_cnt     = ecnt_q;

endmodule

// File: tb/tb_crc_check_byteen.sv
// Bench for crc_check_byteen: 512-bit literal checks plus a 64-bit
// instance compared every cycle against a reflected CRC-32 frame model.
module tb_crc_check_byteen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [511:0] d5;
    logic [63:0]  be5;
    logic         l5, e5;
    logic         v5, ok5, er5, ru5;
    logic [31:0]  r5, fc5, ec5;

    logic [63:0]  d6;
    logic [7:0]   be6;
    logic         l6, e6;
    logic         v6, ok6, er6, ru6;
    logic [31:0]  r6, fc6, ec6;

    crc_check_byteen #(.DWIDTH(512)) u512 (
        .clk(clk), .rst_n(rst_n), .din(d5), .byteEn(be5),
        .dlast(l5), .flitEn(e5), .crc_vld(v5), .crc_ok(ok5),
        .crc_err(er5), .runt(ru5), .crc_residue(r5),
        .frame_cnt(fc5), .err_cnt(ec5)
    );

    crc_check_byteen #(.DWIDTH(64)) u64 (
        .clk(clk), .rst_n(rst_n), .din(d6), .byteEn(be6),
        .dlast(l6), .flitEn(e6), .crc_vld(v6), .crc_ok(ok6),
        .crc_err(er6), .runt(ru6), .crc_residue(r6),
        .frame_cnt(fc6), .err_cnt(ec6)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reflected CRC-32 (LSB-first shift, reversed polynomial)
    function automatic logic [31:0] crc32_ref(input logic [7:0] q[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'd0, q[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    typedef struct {
        int          due;
        logic        ok;
        logic        runt;
        logic [31:0] res;
    } exp_t;

    exp_t        eq[$];
    logic [7:0]  mq[$];
    logic [7:0]  pq[$];
    logic [7:0]  mk[$];
    int          m_fc = 0;
    int          m_ec = 0;
    logic        h_ok = 0, h_err = 0, h_runt = 0;
    logic [31:0] h_res = 0;

    // Drive one 64-bit flit and feed the frame model
    task automatic drive64(input logic [63:0] d, input logic [7:0] be,
                           input logic last, input logic en);
        exp_t x;
        @(negedge clk);
        #1;
        d6 = d; be6 = be; l6 = last; e6 = en;
        if (en) begin
            for (int i = 0; i < 8; i++)
                if (be[i]) mq.push_back(d[8*i +: 8]);
            if (last) begin
                x.due  = cyc + 3;
                x.res  = crc32_ref(mq);
                x.runt = mq.size() < 4;
                x.ok   = !x.runt && (x.res == 32'h2144DF1C);
                eq.push_back(x);
                mq.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive64({$urandom, $urandom}, 8'($urandom), 1'($urandom), 1'b0);
    endtask

    // Spread pq across flits using masks in mk; disabled lanes get junk
    task automatic send();
        int          idx;
        logic [63:0] d;
        idx = 0;
        for (int f = 0; f < mk.size(); f++) begin
            d = {$urandom, $urandom};
            for (int l = 0; l < 8; l++)
                if (mk[f][l] && idx < pq.size()) begin
                    d[8*l +: 8] = pq[idx];
                    idx++;
                end
            drive64(d, mk[f], f == mk.size() - 1, 1'b1);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        e6 = 1'b0; e5 = 1'b0;
        mq.delete(); eq.delete();
        m_fc = 0; m_ec = 0;
        h_ok = 0; h_err = 0; h_runt = 0; h_res = 0;
        repeat (n) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison of the 64-bit instance against the model
    initial begin
        exp_t x;
        logic ev;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_vld",  {31'd0, v6},  32'd0);
                chk("rst_ok",   {31'd0, ok6}, 32'd0);
                chk("rst_err",  {31'd0, er6}, 32'd0);
                chk("rst_runt", {31'd0, ru6}, 32'd0);
                chk("rst_res",  r6,  32'd0);
                chk("rst_fc",   fc6, 32'd0);
                chk("rst_ec",   ec6, 32'd0);
            end else begin
                ev = eq.size() > 0 && eq[0].due == cyc;
                chk("vld", {31'd0, v6}, {31'd0, ev});
                if (ev) begin
                    x = eq.pop_front();
                    m_fc++;
                    if (!x.ok) m_ec++;
                    h_ok = x.ok; h_err = !x.ok;
                    h_runt = x.runt; h_res = x.res;
                end
                chk("ok",   {31'd0, ok6}, {31'd0, h_ok});
                chk("err",  {31'd0, er6}, {31'd0, h_err});
                chk("runt", {31'd0, ru6}, {31'd0, h_runt});
                chk("res",  r6,  h_res);
                chk("fc",   fc6, 32'(m_fc));
                chk("ec",   ec6, 32'(m_ec));
            end
        end
    end

    task automatic f512(input string nm, input logic exp_ok,
                        input logic [31:0] exp_fc, input logic [31:0] exp_ec);
        @(negedge clk);
        #1;
        e5 = 1'b1; l5 = 1'b1; be5 = 64'h1FFF;
        @(negedge clk);
        chk({nm, "_vld_t1"}, {31'd0, v5}, 32'd0);
        #1;
        e5 = 1'b0; l5 = 1'b0;
        @(negedge clk);
        chk({nm, "_vld_t2"}, {31'd0, v5}, 32'd0);
        @(negedge clk);
        chk({nm, "_vld"},  {31'd0, v5},  32'd1);
        chk({nm, "_ok"},   {31'd0, ok5}, {31'd0, exp_ok});
        chk({nm, "_err"},  {31'd0, er5}, {31'd0, !exp_ok});
        chk({nm, "_runt"}, {31'd0, ru5}, 32'd0);
        chk({nm, "_fc"},   fc5, exp_fc);
        chk({nm, "_ec"},   ec5, exp_ec);
        if (exp_ok) chk({nm, "_res"}, r5, 32'h2144DF1C);
        @(negedge clk);
        chk({nm, "_pulse"}, {31'd0, v5}, 32'd0);
        chk({nm, "_hold"},  {31'd0, ok5}, {31'd0, exp_ok});
    endtask

    initial begin
        logic [31:0] c;
        logic [7:0]  zq[$];

        rst_n = 1'b0;
        d5 = '0; be5 = '0; l5 = 1'b0; e5 = 1'b0;
        d6 = '0; be6 = '0; l6 = 1'b0; e6 = 1'b0;

        pq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
               8'h38, 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};

        zq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("model_check", crc32_ref(zq), 32'hCBF43926);
        chk("model_resid", crc32_ref(pq), 32'h2144DF1C);
        zq = '{8'h00, 8'h00, 8'h00, 8'h00};
        chk("model_zero4", crc32_ref(zq), 32'h2144DF1C);

        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;

        d5 = {16{$urandom}};
        for (int i = 0; i < 13; i++) d5[8*i +: 8] = pq[i];
        f512("w512_good", 1'b1, 32'd1, 32'd0);
        d5[0] = ~d5[0];
        f512("w512_bad", 1'b0, 32'd2, 32'd1);

        drive64(64'h3837363534333231, 8'hFF, 1'b0, 1'b1);
        idle(2);
        drive64(64'hA5A5A5CBF4392639, 8'h1F, 1'b1, 1'b1);
        idle(2);

        mk = '{8'hF0, 8'hF0, 8'h1F};
        send();
        idle(1);
        mk = '{8'h5A, 8'h00, 8'hC3, 8'h1F};
        send();
        idle(1);

        drive64(64'hFFFFFFFFFF333231, 8'h07, 1'b1, 1'b1);
        drive64(64'h0123456789ABCDEF, 8'h00, 1'b1, 1'b1);
        pq[0] = 8'h30;
        mk = '{8'hFF, 8'h1F};
        send();
        idle(4);
        chk("drain1", 32'(eq.size()), 32'd0);

        do_reset(2);
        zq = '{8'h41, 8'h42, 8'h43, 8'h44};
        c = crc32_ref(zq);
        drive64({c[31:24], c[23:16], c[15:8], c[7:0], 32'h44434241}, 8'hFF, 1'b1, 1'b1);
        drive64({c[31:24], c[23:16], c[15:8], c[7:0], 32'h44434341}, 8'hFF, 1'b1, 1'b1);
        drive64(64'hDEADBEEF00000000, 8'h0F, 1'b1, 1'b1);
        idle(4);
        chk("b2b_fc", fc6, 32'd3);
        chk("b2b_ec", ec6, 32'd1);

        pq[0] = 8'h31;
        drive64(64'h3837363534333231, 8'hFF, 1'b0, 1'b1);
        do_reset(2);
        mk = '{8'hFF, 8'h1F};
        send();
        idle(4);
        chk("rst_fc", fc6, 32'd1);
        chk("rst_ec", ec6, 32'd0);
        chk("rst_ok", {31'd0, ok6}, 32'd1);
        chk("drain2", 32'(eq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
